// File: rtl/clkdiv_pkg.sv
// Shared constants and configuration type for the multi-channel clock divider.
package clkdiv_pkg;

   localparam int CNT_W_DEF      = 16;
   localparam int DEF_PERIOD_DEF = 100;
   localparam int MIN_PERIOD     = 2;

   // Per-channel divider configuration at the default counter width.
   typedef struct packed {
      logic [CNT_W_DEF-1:0] period;
      logic [CNT_W_DEF-1:0] high;
   } ch_cfg_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active and pending (P,H) registers,
// and registered clk_out/tick.
// The tick flop exists only when CLOCK_DIVIDER_MULTI_TICK_EN is defined;
// otherwise tick is tied low.
// wr is a one-cycle strobe with no back-pressure: every strobe is taken into
// the pending registers on the edge where it is high.
module clkdiv_channel import clkdiv_pkg::*; #(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DEF_PERIOD = DEF_PERIOD_DEF
) (
   input  logic             baseclock,
   input  logic             reset_n,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_period,
   input  logic [CNT_W-1:0] wr_high,
   output logic             clk_out,
   output logic             tick
);

   typedef struct packed {
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] high;
   } cfg_t;

   localparam cfg_t RESET_CFG = '{period: CNT_W'(DEF_PERIOD), high: CNT_W'(DEF_PERIOD / 2)};

   cfg_t             act_q;
   cfg_t             pend_q;
   cfg_t             eff;
   logic             pend_v_q;
   logic             run_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_n;
   logic             wrap;
   logic             apply;
   logic             clk_n;

   // Next count and the configuration that governs the next cycle.
   always_comb begin
      wrap  = run_q && (cnt_q == act_q.period - CNT_W'(1));
      apply = pend_v_q && (!en || !run_q || sync || wrap);
      eff   = apply ? pend_q : act_q;
      cnt_n = '0;
      if (en && run_q && !sync && !wrap) begin
         cnt_n = cnt_q + CNT_W'(1);
      end
      clk_n = en && (cnt_n < eff.high);
   end

   // Counter, run flag, active/pending configuration and clk_out flop.
   always_ff @(posedge baseclock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         run_q    <= 1'b0;
         act_q    <= RESET_CFG;
         pend_q   <= RESET_CFG;
         pend_v_q <= 1'b0;
         clk_out  <= 1'b0;
      end else begin
         cnt_q   <= cnt_n;
         run_q   <= en;
         clk_out <= clk_n;
         if (apply) begin
            act_q    <= pend_q;
            pend_v_q <= 1'b0;
         end
         // A write on the applying edge is kept for the next boundary.
         if (wr) begin
            pend_q   <= '{period: wr_period, high: wr_high};
            pend_v_q <= 1'b1;
         end
      end
   end

`ifdef CLOCK_DIVIDER_MULTI_TICK_EN
   logic tick_q;

   // Tick is high while the count sits on the last cycle of its period.
   always_ff @(posedge baseclock or negedge reset_n) begin
      if (!reset_n) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= en && (cnt_n == eff.period - CNT_W'(1));
      end
   end

   assign tick = tick_q;
`else
   assign tick = 1'b0;
`endif

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: shared config bus with write
// validation and a cfg_err pulse, NUM_CH independent divider channels.
// Define CLOCK_DIVIDER_MULTI_TICK_EN to build the per-channel tick logic.
// cfg_we is a one-cycle strobe with no ready: a good write is always taken,
// a bad one (period below MIN_PERIOD or channel out of range) is dropped and
// flagged on cfg_err in the following cycle.
module clock_divider_multi import clkdiv_pkg::*; #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DEF_PERIOD = DEF_PERIOD_DEF
) (
   input  logic                                         baseclock,
   input  logic                                         reset_n,
   input  logic                                         cfg_we,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]                             cfg_period,
   input  logic [CNT_W-1:0]                             cfg_high,
   output logic                                         cfg_err,
   input  logic [NUM_CH-1:0]                            ch_en,
   input  logic                                         sync,
   output logic [NUM_CH-1:0]                            clk_out,
   output logic [NUM_CH-1:0]                            tick
);

   logic              cfg_ok;
   logic [NUM_CH-1:0] wr_sel;

   // Validate the write and steer it to exactly one channel.
   always_comb begin
      cfg_ok = (cfg_period >= CNT_W'(MIN_PERIOD)) && (32'(cfg_ch) < 32'(NUM_CH));
      wr_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_sel[i] = cfg_we && cfg_ok && (32'(cfg_ch) == 32'(i));
      end
   end

   // Rejected writes pulse cfg_err for one cycle.
   always_ff @(posedge baseclock or negedge reset_n) begin
      if (!reset_n) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !cfg_ok;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clkdiv_channel #(
         .CNT_W      (CNT_W),
         .DEF_PERIOD (DEF_PERIOD)
      ) u_ch (
         .baseclock (baseclock),
         .reset_n   (reset_n),
         .en        (ch_en[g]),
         .sync      (sync),
         .wr        (wr_sel[g]),
         .wr_period (cfg_period),
         .wr_high   (cfg_high),
         .clk_out   (clk_out[g]),
         .tick      (tick[g])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed scenarios, a write-vector table and
// random traffic, all compared against a timeline model of the divider.
module tb_clock_divider_multi;

   localparam int NUM_CH     = 4;
   localparam int CNT_W      = 16;
   localparam int DEF_PERIOD = 100;
`ifdef CLOCK_DIVIDER_MULTI_TICK_EN
   localparam bit TICK_ON = 1'b1;
`else
   localparam bit TICK_ON = 1'b0;
`endif

   logic              baseclock = 1'b0;
   logic              reset_n;
   logic              cfg_we;
   logic [1:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_period;
   logic [CNT_W-1:0]  cfg_high;
   logic              cfg_err;
   logic [NUM_CH-1:0] ch_en;
   logic              sync;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   always #5 baseclock = ~baseclock;

   clock_divider_multi #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD)
   ) dut (
      .baseclock  (baseclock),
      .reset_n    (reset_n),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_err    (cfg_err),
      .ch_en      (ch_en),
      .sync       (sync),
      .clk_out    (clk_out),
      .tick       (tick)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Timeline model: each running channel remembers the cycle number at
   // which its current period started; its phase is cyc - t0.
   int          cyc;
   int          m_p  [NUM_CH];
   int          m_h  [NUM_CH];
   int          m_pp [NUM_CH];
   int          m_ph [NUM_CH];
   bit          m_pv [NUM_CH];
   bit          m_run[NUM_CH];
   int          m_t0 [NUM_CH];
   logic [3:0]  e_clk;
   logic [3:0]  e_tick;
   logic        e_err;

   typedef struct {
      logic [1:0]       ch;
      logic [CNT_W-1:0] p;
      logic [CNT_W-1:0] h;
      logic             err;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      cyc = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_p[i]   = DEF_PERIOD;
         m_h[i]   = DEF_PERIOD / 2;
         m_pp[i]  = 0;
         m_ph[i]  = 0;
         m_pv[i]  = 1'b0;
         m_run[i] = 1'b0;
         m_t0[i]  = 0;
      end
      e_clk  = '0;
      e_tick = '0;
      e_err  = 1'b0;
   endtask

   function automatic int pos(input int ch);
      return cyc - m_t0[ch];
   endfunction

   // Called once per rising edge with the inputs that edge samples.
   task automatic model_edge();
      bit ok;
      bit restart;
      int age;
      cyc++;
      ok    = cfg_we && (int'(cfg_period) >= 2) && (int'(cfg_ch) < NUM_CH);
      e_err = cfg_we && !ok;
      for (int i = 0; i < NUM_CH; i++) begin
         age     = cyc - 1 - m_t0[i];
         restart = !ch_en[i] || !m_run[i] || sync || (age == m_p[i] - 1);
         if (m_pv[i] && restart) begin
            m_p[i]  = m_pp[i];
            m_h[i]  = m_ph[i];
            m_pv[i] = 1'b0;
         end
         if (ok && int'(cfg_ch) == i) begin
            m_pp[i] = int'(cfg_period);
            m_ph[i] = int'(cfg_high);
            m_pv[i] = 1'b1;
         end
         if (!ch_en[i]) begin
            m_run[i]  = 1'b0;
            e_clk[i]  = 1'b0;
            e_tick[i] = 1'b0;
         end else begin
            if (restart) m_t0[i] = cyc;
            m_run[i]  = 1'b1;
            e_clk[i]  = (cyc - m_t0[i]) < m_h[i];
            e_tick[i] = TICK_ON && ((cyc - m_t0[i]) == m_p[i] - 1);
         end
      end
   endtask

   // One clock: model follows the edge, outputs checked on the falling edge,
   // then the one-cycle strobes are dropped.
   task automatic step();
      @(posedge baseclock);
      model_edge();
      @(negedge baseclock);
      check("clk_out", 32'(clk_out), 32'(e_clk));
      check("tick", 32'(tick), 32'(e_tick));
      check("cfg_err", 32'(cfg_err), 32'(e_err));
      cfg_we = 1'b0;
      sync   = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic run_count(input int n, input int ch, output int highs, output int ticks);
      highs = 0;
      ticks = 0;
      repeat (n) begin
         step();
         if (clk_out[ch]) highs++;
         if (tick[ch]) ticks++;
      end
   endtask

   task automatic write_set(input logic [1:0] ch, input int p, input int h);
      cfg_we     = 1'b1;
      cfg_ch     = ch;
      cfg_period = CNT_W'(p);
      cfg_high   = CNT_W'(h);
   endtask

   initial begin
      int highs;
      int ticks;
      int guard;
      int bit_idx;

      vecs[0] = '{ch: 2'd2, p: 16'd1,  h: 16'd1,  err: 1'b1};
      vecs[1] = '{ch: 2'd0, p: 16'd0,  h: 16'd0,  err: 1'b1};
      vecs[2] = '{ch: 2'd1, p: 16'd10, h: 16'd3,  err: 1'b0};
      vecs[3] = '{ch: 2'd3, p: 16'd2,  h: 16'd1,  err: 1'b0};
      vecs[4] = '{ch: 2'd2, p: 16'd20, h: 16'd20, err: 1'b0};
      vecs[5] = '{ch: 2'd0, p: 16'd8,  h: 16'd0,  err: 1'b0};
      vecs[6] = '{ch: 2'd3, p: 16'd5,  h: 16'd9,  err: 1'b0};
      vecs[7] = '{ch: 2'd1, p: 16'd1,  h: 16'd1,  err: 1'b1};

      reset_n    = 1'b0;
      cfg_we     = 1'b0;
      cfg_ch     = '0;
      cfg_period = '0;
      cfg_high   = '0;
      ch_en      = '0;
      sync       = 1'b0;
      model_reset();

      // Reset state.
      repeat (3) @(negedge baseclock);
      check("reset_clk_out", 32'(clk_out), 32'd0);
      check("reset_tick", 32'(tick), 32'd0);
      check("reset_cfg_err", 32'(cfg_err), 32'd0);
      reset_n = 1'b1;
      run(2);

      // Default 100-cycle period on channel 0.
      ch_en = 4'b0001;
      run_count(100, 0, highs, ticks);
      check("default_high_cycles", 32'(highs), 32'd50);
      check("default_ticks", 32'(ticks), TICK_ON ? 32'd1 : 32'd0);

      // Mid-period reprogram of channel 1: old period completes first.
      ch_en = 4'b0011;
      run(37);
      write_set(2'd1, 10, 3);
      run(70);
      run_count(30, 1, highs, ticks);
      check("ch1_p10_high_cycles", 32'(highs), 32'd9);
      check("ch1_p10_ticks", 32'(ticks), TICK_ON ? 32'd3 : 32'd0);

      // Rejected write: error pulse, channel 2 keeps its defaults.
      write_set(2'd2, 1, 1);
      step();
      check("p1_err_pulse", 32'(cfg_err), 32'd1);
      step();
      check("p1_err_clear", 32'(cfg_err), 32'd0);
      ch_en = 4'b0111;
      run_count(100, 2, highs, ticks);
      check("ch2_default_high", 32'(highs), 32'd50);

      // Write landing on channel 0's wrap cycle applies one period later.
      guard = 0;
      while (pos(0) != DEF_PERIOD - 1 && guard < 300) begin
         step();
         guard++;
      end
      check("wrap_search_bound", 32'(pos(0)), 32'(DEF_PERIOD - 1));
      write_set(2'd0, 4, 2);
      run_count(100, 0, highs, ticks);
      check("wrap_write_old_period", 32'(highs), 32'd50);
      run_count(8, 0, highs, ticks);
      check("wrap_write_new_period", 32'(highs), 32'd4);

      // Sync realigns channels 0 and 1 and applies their pending configs.
      write_set(2'd0, 6, 3);
      step();
      write_set(2'd1, 9, 4);
      step();
      run(5);
      sync = 1'b1;
      step();
      check("sync_aligned_high", 32'(clk_out[1:0]), 32'd3);
      run(20);

      // Table of configuration writes with all channels running.
      ch_en = 4'b1111;
      for (int v = 0; v < 8; v++) begin
         write_set(vecs[v].ch, int'(vecs[v].p), int'(vecs[v].h));
         step();
         check("vec_err", 32'(cfg_err), 32'(vecs[v].err));
         run(3);
      end
      run(40);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            write_set(2'($urandom_range(0, 3)), int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
         end
         if ($urandom_range(0, 39) == 0) sync = 1'b1;
         if ($urandom_range(0, 29) == 0) begin
            bit_idx = int'($urandom_range(0, NUM_CH - 1));
            ch_en[bit_idx] = ~ch_en[bit_idx];
         end
         step();
      end

      // Reset mid-period with a pending write on channel 2.
      ch_en = 4'b1111;
      run(5);
      write_set(2'd2, 12, 6);
      step();
      run(3);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_clk_out", 32'(clk_out), 32'd0);
      check("async_reset_tick", 32'(tick), 32'd0);
      check("async_reset_cfg_err", 32'(cfg_err), 32'd0);
      model_reset();
      repeat (2) @(negedge baseclock);
      reset_n = 1'b1;
      run_count(100, 2, highs, ticks);
      check("post_reset_ch2_high", 32'(highs), 32'd50);
      check("post_reset_ch2_ticks", 32'(ticks), TICK_ON ? 32'd1 : 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_divider_multi.md
CLOCK_DIVIDER_MULTI -- requirements
Module: clock_divider_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16: counter, period and high-time width.
REQ-003 SHALL have parameter DEF_PERIOD, default 100: period after reset; DEF_PERIOD>=2.
REQ-004 SHALL have port baseclock  input  1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port cfg_we  input  1: one-cycle configuration write strobe.
REQ-007 SHALL have port cfg_ch  input  $clog2(NUM_CH) (min 1): target channel of write.
REQ-008 SHALL have port cfg_period  input  CNT_W: new period P in baseclock cycles.
REQ-009 SHALL have port cfg_high  input  CNT_W: new high time H in baseclock cycles.
REQ-010 SHALL have port cfg_err  output  1: one-cycle pulse, write rejected.
REQ-011 SHALL have port ch_en  input  NUM_CH: per-channel run enable, level.
REQ-012 SHALL have port sync  input  1: one-cycle phase-realign strobe for all channels.
REQ-013 SHALL have port clk_out  output  NUM_CH: divided clocks, registered.
REQ-014 SHALL have port tick  output  NUM_CH: one-cycle pulse at each period end.

Function
REQ-015 Each enabled channel SHALL count 0..P-1 then wrap to 0; counter==P-1 is the wrap cycle.
REQ-016 clk_out[i] SHALL be a flop equal to (current count < H): H=0 gives constant low, H>=P constant high, H=P/2 symmetric for even P.
REQ-017 tick[i] SHALL be high exactly during the wrap cycle of an enabled channel.
REQ-018 A write with cfg_period<2 or cfg_ch>=NUM_CH SHALL be ignored and pulse cfg_err the next cycle.
REQ-019 An accepted write SHALL load a per-channel pending (P,H) and set a pending flag; a second write before application overwrites it.
REQ-020 Pending values SHALL become active on the cycle after the channel's next wrap, at sync, or immediately if the channel is disabled.
REQ-021 A write in the same cycle as that channel's wrap SHALL NOT apply at that wrap; it applies at the following one.
REQ-022 Disabled channel: counter held 0, clk_out 0, tick 0.
REQ-023 On ch_en rising, counting SHALL start at 0 next cycle; clk_out high that cycle if H>0.
REQ-024 sync SHALL reset all enabled counters to 0 next cycle and apply pending configs; sync overrides a coincident wrap (no tick generated by sync).
REQ-025 Channels SHALL be fully independent apart from sync and the shared config bus.

Reset
REQ-026 reset_n low SHALL asynchronously force: counters 0, active P=DEF_PERIOD, H=DEF_PERIOD/2, pending flags 0, clk_out 0, tick 0, cfg_err 0.
REQ-027 After reset release, the first edge with ch_en[i]=1 SHALL behave as REQ-023.
REQ-028 Reset asserted mid-period SHALL discard pending configuration.

Configuration
REQ-029 Macro CLOCK_DIVIDER_MULTI_TICK_EN defined: tick port and logic present per REQ-017.
REQ-030 Macro undefined: tick port SHALL still exist but be tied to 0; no tick logic synthesised; all other behaviour unchanged.

Structure
REQ-031 Package clkdiv_pkg SHALL hold CNT_W default, DEF_PERIOD default, MIN_PERIOD=2 constant and the per-channel config struct type (period, high).
REQ-032 One sub-module clkdiv_channel (counter, active/pending regs, clk_out/tick flops) SHALL be instantiated NUM_CH times; top holds write decode and cfg_err.

Verification
REQ-033 Reset, ch_en=4'b0001, no writes -> clk_out[0] 50 high / 50 low, tick[0] every 100 cycles; others 0.
REQ-034 Write ch1 P=10 H=3 while enabled mid-period -> old period completes, then 3 high / 7 low, tick period 10.
REQ-035 Write ch2 P=1 -> cfg_err pulse one cycle later; ch2 keeps P=100 H=50.
REQ-036 Write on ch0 exactly in its wrap cycle (P=4 new) -> one more P=100 period, then P=4.
REQ-037 ch0 P=6, ch1 P=9 running, sync pulse -> both counters 0 next cycle, both clk_out high, rising edges aligned.
REQ-038 reset_n asserted mid-period with pending write -> outputs 0 immediately; after release, default 100-cycle period, pending lost.
